// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one unified instruction/data memory between the IF-stage fetch port
// and the MEM-stage load/store port. A request is sampled only in IDLE, the
// winner's address/control is latched, the memory strobes are held for
// ACC_CYC cycles, and the owner then gets a one-cycle ready pulse.
//
// Handshake (both ports): the requester raises *_req together with its
// address/control and holds all of them stable until it sees its *_ready
// pulse. *_ready is high for exactly one cycle per completed access, and
// *_rdata is valid while *_ready is high (and holds until the next load/fetch
// completion on that port). A request seen while the arbiter is not IDLE is
// simply not sampled yet.
//
// Parameters:
//   ACC_CYC    memory cycles per access (>=1)
//   STARVE_MAX consecutive data grants allowed while a fetch waits (>=1);
//              only used when ARB_STARVE_GUARD_EN is defined
//
// Optional feature macro: ARB_STARVE_GUARD_EN
//   defined   -> after STARVE_MAX data grants issued while if_req was high,
//                a contended grant goes to fetch
//   undefined -> strict data priority, fetch may starve
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   if_req/if_addr               fetch request (word access, func3 = 3'b010)
//   if_rdata/if_ready            fetched word and its completion pulse
//   d_req/d_we/d_func3/d_addr/d_wdata  load/store request
//   d_rdata/d_ready              load data and completion pulse
//   mem_addr/mem_func3/mem_wdata/mem_read/mem_write  to data memory
//   mem_rdata                    from data memory
//   busy                         high whenever the sequencer is not IDLE
//   dbg_state                    current sequencer state (IDLE/ACCESS/RESP)
module mem_port_arbiter #(
  parameter int ACC_CYC    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_func3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic [31:0] mem_addr,
  output logic [2:0]  mem_func3,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int CW = (ACC_CYC < 2) ? 1 : $clog2(ACC_CYC + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;

  // Latched request of the current owner.
  logic          lat_d;      // 1 = data port owns the access
  logic          lat_we;
  logic [31:0]   lat_addr;
  logic [2:0]    lat_f3;
  logic [31:0]   lat_wdata;

  logic          any_req;
  logic          grant_d;    // winner if a grant happens this cycle

  assign any_req = if_req | d_req;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_cnt;

  // Data normally wins a tie (it belongs to the older instruction), unless
  // fetch has already been passed over STARVE_MAX times in a row.
  always_comb begin
    grant_d = d_req & ~(if_req & (starve_cnt == SW'(STARVE_MAX)));
  end

  // Counts data grants made while fetch was waiting; any fetch grant or a
  // grant with no fetch pending breaks the streak.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (state == IDLE && any_req) begin
      if (grant_d && if_req) begin
        starve_cnt <= starve_cnt + SW'(1);
      end else begin
        starve_cnt <= '0;
      end
    end
  end
`else
  always_comb begin
    grant_d = d_req;
  end
`endif

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  if (cnt == CW'(1)) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter, request latch and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_d     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_f3    <= '0;
      lat_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (any_req) begin
            cnt   <= CW'(ACC_CYC);
            lat_d <= grant_d;
            if (grant_d) begin
              lat_we    <= d_we;
              lat_addr  <= d_addr;
              lat_f3    <= d_func3;
              lat_wdata <= d_wdata;
            end else begin
              lat_we    <= 1'b0;
              lat_addr  <= if_addr;
              lat_f3    <= 3'b010;
              lat_wdata <= '0;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt - CW'(1);
          // Last access cycle: memory output is settled, capture it for the
          // owner. Stores leave the data read register untouched.
          if (cnt == CW'(1) && !lat_we) begin
            if (lat_d) begin
              d_rdata <= mem_rdata;
            end else begin
              if_rdata <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Memory strobes and ready pulses decoded from the state.
  always_comb begin
    mem_addr  = '0;
    mem_func3 = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (state == ACCESS) begin
      mem_addr  = lat_addr;
      mem_func3 = lat_f3;
      mem_wdata = lat_wdata;
      mem_read  = ~lat_we;
      // Write strobe only in the first access cycle so a store lands once.
      mem_write = lat_we & (cnt == CW'(ACC_CYC));
    end
    if_ready = (state == RESP) & ~lat_d;
    d_ready  = (state == RESP) & lat_d;
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int ACC_CYC    = 2;
  localparam int STARVE_MAX = 3;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_func3;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic [31:0] mem_addr;
  logic [2:0]  mem_func3;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic        busy;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ACC_CYC(ACC_CYC), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_func3(d_func3), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_addr(mem_addr), .mem_func3(mem_func3), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .busy(busy), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst       = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_func3   = '0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_strobes"}, {27'd0, busy, mem_read, mem_write, if_ready, d_ready}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_func3"}, {29'd0, mem_func3}, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_if_rdata"}, if_rdata, 32'd0);
    chk({tag, "_d_rdata"}, d_rdata, 32'd0);
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic        ir;
    logic        dr;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] wd;
    logic [31:0] mr;
    logic        exp_d_first;
    logic [31:0] exp_rd;
    int          exp_lat2;
    int          exp_reads;
    int          exp_writes;
    logic [31:0] exp_addr;
    logic [2:0]  exp_f3;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input int idx, input vec_t v);
    int          n_read  = 0;
    int          n_write = 0;
    int          lat1    = -1;
    int          lat2    = -1;
    logic        first_d = 1'b0;
    logic [31:0] rd1     = '0;
    logic        got_a   = 1'b0;
    logic [31:0] s_addr  = '0;
    logic [2:0]  s_f3    = '0;
    logic [31:0] s_wd    = '0;
    if_req    = v.ir;
    if_addr   = v.ia;
    d_req     = v.dr;
    d_we      = v.we;
    d_func3   = v.f3;
    d_addr    = v.da;
    d_wdata   = v.wd;
    mem_rdata = v.mr;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk($sformatf("vec%0d_both_ready", idx), {31'd0, if_ready & d_ready}, 32'd0);
      if (mem_read)  n_read++;
      if (mem_write) begin
        n_write++;
        s_wd = mem_wdata;
      end
      if ((mem_read || mem_write) && !got_a) begin
        got_a  = 1'b1;
        s_addr = mem_addr;
        s_f3   = mem_func3;
      end
      if (if_ready || d_ready) begin
        if (lat1 < 0) begin
          lat1    = k;
          first_d = d_ready;
          rd1     = d_ready ? d_rdata : if_rdata;
        end else if (lat2 < 0) begin
          lat2 = k;
        end
        if (d_ready)  d_req  = 1'b0;
        if (if_ready) if_req = 1'b0;
      end
    end
    chk($sformatf("vec%0d_lat1", idx), lat1, ACC_CYC + 1);
    chk($sformatf("vec%0d_owner", idx), {31'd0, first_d}, {31'd0, v.exp_d_first});
    chk($sformatf("vec%0d_rdata", idx), rd1, v.exp_rd);
    chk($sformatf("vec%0d_lat2", idx), lat2, v.exp_lat2);
    chk($sformatf("vec%0d_reads", idx), n_read, v.exp_reads);
    chk($sformatf("vec%0d_writes", idx), n_write, v.exp_writes);
    chk($sformatf("vec%0d_addr", idx), s_addr, v.exp_addr);
    chk($sformatf("vec%0d_func3", idx), {29'd0, s_f3}, {29'd0, v.exp_f3});
    chk($sformatf("vec%0d_wdata", idx), s_wd, v.exp_wdata);
  endtask

  // ---------------- reset in the middle of an access ----------------
  task automatic run_mid_reset();
    int lat = -1;
    do_reset();
    if_req    = 1'b1;
    if_addr   = 32'h20;
    mem_rdata = 32'h11111111;
    @(negedge clk);
    chk("midrst_access_read", {31'd0, mem_read}, 32'd1);
    chk("midrst_access_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_read_low", {31'd0, mem_read}, 32'd0);
    chk("midrst_busy_low", {31'd0, busy}, 32'd0);
    chk("midrst_no_ready", {30'd0, if_ready, d_ready}, 32'd0);
    chk("midrst_if_rdata", if_rdata, 32'd0);
    rst       = 1'b0;
    mem_rdata = 32'h22222222;
    for (int k = 1; k <= 10 && lat < 0; k++) begin
      @(negedge clk);
      if (if_ready) begin
        lat = k;
        chk("midrst_fresh_rdata", if_rdata, 32'h22222222);
        if_req = 1'b0;
      end
    end
    chk("midrst_fresh_lat", lat, ACC_CYC + 1);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- starvation ----------------
  task automatic run_starve();
    logic got[8];
    int   n = 0;
    int   s = 0;
    logic exp_d;
    do_reset();
    if_req  = 1'b1;
    if_addr = 32'h100;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_func3 = 3'b010;
    d_addr  = 32'h200;
    for (int k = 0; k < 80 && n < 8; k++) begin
      @(negedge clk);
      mem_rdata = $urandom;
      if (if_ready || d_ready) begin
        got[n] = d_ready;
        n++;
      end
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    chk("starve_completions", n, 8);
    for (int i = 0; i < n; i++) begin
`ifdef ARB_STARVE_GUARD_EN
      if (s == STARVE_MAX) begin
        exp_d = 1'b0;
        s     = 0;
      end else begin
        exp_d = 1'b1;
        s++;
      end
`else
      exp_d = 1'b1;
`endif
      chk($sformatf("starve_grant%0d", i), {31'd0, got[i]}, {31'd0, exp_d});
    end
    repeat (4) @(negedge clk);
  endtask

  // ---------------- random stimulus vs. transaction-level model ----------------
  // The model tracks the active access as a start period plus owner, and
  // derives expected strobes from period arithmetic: access occupies
  // [start, start+ACC_CYC), the ready pulse is at start+ACC_CYC, and the
  // arbiter can sample again one period later.
  task automatic run_random(input int n);
    int          free_at   = 0;
    int          acc_start = 0;
    bit          m_act     = 0;
    bit          m_d       = 0;
    bit          m_we      = 0;
    logic [31:0] m_addr    = '0;
    logic [2:0]  m_f3      = '0;
    logic [31:0] m_wd      = '0;
    logic [31:0] m_if_rd   = '0;
    logic [31:0] m_d_rd    = '0;
    int          starve    = 0;
    bit          if_pend   = 0;
    bit          d_pend    = 0;
    bit          in_acc;
    bit          in_resp;
    bit          take_d;
    logic [4:0]  e_str;
    logic [0:0]  exp_q[$];
    logic [0:0]  e_own;
    do_reset();
    for (int p = 0; p < n; p++) begin
      if (p > 0) @(negedge clk);
      in_acc  = m_act && p >= acc_start && p < acc_start + ACC_CYC;
      in_resp = m_act && p == acc_start + ACC_CYC;
      e_str   = {in_acc | in_resp, in_acc & ~m_we, in_acc & m_we & (p == acc_start),
                 in_resp & ~m_d, in_resp & m_d};
      chk("rand_strobes", {27'd0, busy, mem_read, mem_write, if_ready, d_ready}, {27'd0, e_str});
      chk("rand_mem_addr", mem_addr, in_acc ? m_addr : 32'd0);
      chk("rand_mem_func3", {29'd0, mem_func3}, in_acc ? {29'd0, m_f3} : 32'd0);
      chk("rand_mem_wdata", mem_wdata, in_acc ? m_wd : 32'd0);
      chk("rand_if_rdata", if_rdata, m_if_rd);
      chk("rand_d_rdata", d_rdata, m_d_rd);
      if (if_ready || d_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_ready", 32'd1, 32'd0);
        end else begin
          e_own = exp_q.pop_front();
          chk("sb_owner", {31'd0, d_ready}, {31'd0, e_own});
        end
      end
      if (in_resp) begin
        if (m_d) d_pend = 0;
        else     if_pend = 0;
        m_act   = 0;
        free_at = p + 1;
      end
      // Requesters: raise a new request at random, hold it until its ready.
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1;
        if_addr = 32'($urandom_range(0, 16383)) << 2;
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend  = 1;
        d_we    = 1'($urandom_range(0, 1));
        d_func3 = 3'($urandom_range(0, 7));
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
      if_req    = if_pend;
      d_req     = d_pend;
      mem_rdata = $urandom;
      if (m_act && !m_we && p == acc_start + ACC_CYC - 1) begin
        if (m_d) m_d_rd  = mem_rdata;
        else     m_if_rd = mem_rdata;
      end
      if (!m_act && p >= free_at && (if_req || d_req)) begin
`ifdef ARB_STARVE_GUARD_EN
        take_d = d_req && !(if_req && starve == STARVE_MAX);
        if (take_d && if_req) starve++;
        else                  starve = 0;
`else
        take_d = d_req;
`endif
        m_act     = 1;
        acc_start = p + 1;
        m_d       = take_d;
        if (take_d) begin
          m_we   = d_we;
          m_addr = d_addr;
          m_f3   = d_func3;
          m_wd   = d_wdata;
        end else begin
          m_we   = 0;
          m_addr = if_addr;
          m_f3   = 3'b010;
          m_wd   = '0;
        end
        exp_q.push_back(take_d);
      end
    end
  endtask

  // ---------------- main ----------------
  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 32'h00500093,
                1'b0, 32'h00500093, -1, 2, 0, 32'h10, 3'b010, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 3'b100, 32'h0, 32'h80, 32'h0, 32'h12345678,
                1'b1, 32'h12345678, -1, 2, 0, 32'h80, 3'b100, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 3'b010, 32'h0, 32'h40, 32'hDEADBEEF, 32'hCAFEF00D,
                1'b1, 32'h12345678, -1, 0, 1, 32'h40, 3'b010, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 3'b010, 32'h14, 32'h84, 32'h0, 32'hA5A5A5A5,
                1'b1, 32'hA5A5A5A5, 7, 4, 0, 32'h84, 3'b010, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 3'b001, 32'h18, 32'h44, 32'h01020304, 32'h00001111,
                1'b1, 32'hA5A5A5A5, 7, 2, 1, 32'h44, 3'b001, 32'h01020304};

    do_reset();
    chk_all_zero("reset");

    for (int i = 0; i < 5; i++) begin
      run_vec(i, vecs[i]);
    end

    run_mid_reset();
    run_starve();
    run_random(600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
